fb_arbiter: RTL and testbench
=============================

# fb_arbiter

Arbiter and sequencer for the single-port frame-buffer RAM behind the VGA display path. It takes the pixel coordinates and syncs from `vgaController` and shares the RAM between three requesters:
- display fetch, which must never miss;
- an optional clear engine;
- a drawing client on a valid/ready handshake.

It outputs a colour index and syncs, both delayed to line up with the RAM read latency.

## Interface
Parameters:
- `FB_W`, 160, frame-buffer width in stored pixels
- `FB_H`, 120, frame-buffer height in stored pixels
- `SCALE_SH`, 2, log2 of the screen-to-frame-buffer pixel scale (4x4 replication)
- `PIX_W`, 4, bits per stored pixel (colour index)
- `ADDR_W`, 15, RAM address width; must satisfy FB_W*FB_H <= 2^ADDR_W
- `H_ACTIVE`, 640, visible columns
- `V_ACTIVE`, 480, visible rows

Ports. The block has one clock; reset is synchronous and active-high.
- `vgaclk`  in  1  pixel clock; all logic on its rising edge
- `reset`  in  1  synchronous, active-high reset
- `x`, `y`  in  10 each  current pixel coordinate from `vgaController`
- `hsync`, `vsync`  in  1 each  syncs from `vgaController`
- `wr_valid`  in  1  draw request
- `wr_ready`  out  1  draw request accepted this cycle
- `wr_x`  in  8  draw x coordinate
- `wr_y`  in  7  draw y coordinate
- `wr_color`  in  PIX_W  draw colour
- `clear_start`  in  1  single-cycle pulse that starts a full-buffer fill
- `clear_color`  in  PIX_W  fill colour, sampled together with `clear_start`
- `clear_busy`  out  1  fill in progress
- `ram_addr`  out  ADDR_W  RAM address
- `ram_we`  out  1  RAM write enable
- `ram_wdata`  out  PIX_W  RAM write data
- `ram_rdata`  in  PIX_W  RAM read data, valid 1 cycle after the address
- `pixel`  out  PIX_W  colour index to the DAC; 0 during blanking
- `hsync_o`, `vsync_o`  out  1 each  syncs aligned with `pixel`

## Operation
- **Display need:** `disp_need = (x < H_ACTIVE) && (y < V_ACTIVE) && (x[SCALE_SH-1:0] == 0)`.
- **Display address:** `(y>>SCALE_SH)*FB_W + (x>>SCALE_SH)`. The multiply is done by shift-add: `(yf<<7)+(yf<<5)` for FB_W=160.
- **Grant priority, fixed, evaluated every cycle:**
  - display when `disp_need`;
  - else clear engine when in CLEAR;
  - else the writer.
- Only one RAM operation happens per cycle. `ram_addr`, `ram_we` and `ram_wdata` are combinational from the grant.
- **Writer:**
  - `wr_ready = !disp_need && !clear_busy`.
  - A transfer happens on `wr_valid && wr_ready`.
  - Out-of-range coordinates (`wr_x >= FB_W` or `wr_y >= FB_H`) are accepted but dropped: `ram_we` = 0 for that transfer.
- **Clear FSM, states IDLE and CLEAR:**
  - IDLE -> CLEAR on `clear_start`. On that edge it latches `clear_color` and sets the address counter to 0.
  - In CLEAR, each cycle without `disp_need` writes the counter address, then increments it.
  - CLEAR -> IDLE after the write to address FB_W*FB_H-1.
  - `clear_start` while in CLEAR is ignored.
- **Display read and pixel output:**
  - A display read issued in cycle t returns `ram_rdata` in t+1.
  - The pixel register loads `ram_rdata` at the end of t+1 only if t was a display read. Otherwise it holds, which gives horizontal replication.
  - `pixel` is forced to 0 when the delayed active flag is 0.
- **Reset values:** `pixel` = 0, `hsync_o` = 1, `vsync_o` = 1, `clear_busy` = 0, FSM = IDLE, counter = 0. `wr_ready` follows its equation.
- **Reset during CLEAR:** the clear aborts, `clear_busy` is 0 on the next cycle, and partially written contents are left as they are.

## Timing
- **Syncs:** `hsync_o`/`vsync_o` are `hsync`/`vsync` delayed by exactly 2 cycles.
- **Pixel latency:** `pixel` for coordinate (x, y) appears 2 cycles after (x, y) is presented, aligned with the syncs.
- **Write bandwidth:** 3 of 4 cycles during active video, every cycle during blanking.
- **Clear duration:** 19200 write cycles plus display-stolen cycles.
- **`clear_busy` timing:**
  - rises the cycle after `clear_start`;
  - falls the cycle after the final write.
- **Writer during clear:** a `wr_valid` held through a clear is accepted on the first free cycle after `clear_busy` falls.
- **Simultaneous events:** if `clear_start` arrives in the same cycle as a writer transfer, the write completes and the clear begins next cycle.

## Configuration
- **`FB_CLEAR_EN` defined:** the clear engine is present as described.
- **`FB_CLEAR_EN` undefined:**
  - no FSM or counter is built;
  - `clear_busy` is tied to 0 and `clear_start`/`clear_color` are ignored;
  - `wr_ready = !disp_need`.

## Structure
- **Package `fb_pkg`:**
  - constants FB_W, FB_H, SCALE_SH, PIX_W, ADDR_W, H_ACTIVE, V_ACTIVE;
  - typedef `fb_addr_t` (logic [ADDR_W-1:0]);
  - typedef `pix_t`;
  - enum `grant_e` {GNT_NONE, GNT_DISP, GNT_CLEAR, GNT_WRITE};
  - enum `clr_state_e` {CLR_IDLE, CLR_RUN}.
- **Sub-module `fb_addr_gen`:** combinational (xf, yf) -> `fb_addr_t` shift-add. It is instantiated twice, once for display and once for the writer.

## Test plan
- **Reset:** assert `reset` for 2 cycles with x=700, y=500 -> `pixel`=0, `hsync_o`=`vsync_o`=1, `clear_busy`=0, `wr_ready`=1.
- **Display fetch:** x=8, y=4 with `ram_rdata`=4'hA returned one cycle later -> `ram_addr`=162, `ram_we`=0. `pixel`=4'hA two cycles later and held for 4 cycles (x=8..11). `hsync_o` equals `hsync` delayed by 2.
- **Writer arbitration:**
  - writer holds `wr_valid` with (10, 3, 4'h5) while x=0, y=0 -> `wr_ready`=0.
  - x advances to 1 -> `wr_ready`=1, `ram_we`=1, `ram_addr`=490, `ram_wdata`=5.
- **Out-of-range write:** `wr_x`=160 during blanking -> `wr_ready`=1, `ram_we`=0.
- **Clear during blanking:** x=700 held, `clear_start` with colour 4'h3 -> `clear_busy` high for exactly 19200 cycles. Addresses 0..19199 are written in order with `ram_wdata`=3. `wr_ready`=0 throughout. A second `clear_start` mid-run has no effect.
- **Reset mid-clear:** `reset` 500 cycles into a clear -> `clear_busy`=0 next cycle; a new `clear_start` restarts at address 0. With `FB_CLEAR_EN` undefined, `clear_start` gives `clear_busy`=0 and no writes.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared constants and types for the frame-buffer arbiter.
// The clear engine is built only when the macro FB_CLEAR_EN is defined.
package fb_pkg;

  localparam int FB_W     = 160;
  localparam int FB_H     = 120;
  localparam int SCALE_SH = 2;
  localparam int PIX_W    = 4;
  localparam int ADDR_W   = 15;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  typedef logic [ADDR_W-1:0] fb_addr_t;
  typedef logic [PIX_W-1:0]  pix_t;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_DISP,
    GNT_CLEAR,
    GNT_WRITE
  } grant_e;

  typedef enum logic {
    CLR_IDLE,
    CLR_RUN
  } clr_state_e;

endpackage

// File: rtl/fb_addr_gen.sv
// Linear frame-buffer address from stored-pixel coordinates: yf*FB_W + xf.
// The multiply is a shift-add at the native 160-pixel width.
module fb_addr_gen #(
  parameter int FB_W   = fb_pkg::FB_W,
  parameter int ADDR_W = fb_pkg::ADDR_W
) (
  input  logic [9:0]        xf,
  input  logic [9:0]        yf,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] xw;
  logic [ADDR_W-1:0] yw;

  assign xw = ADDR_W'(xf);
  assign yw = ADDR_W'(yf);

  generate
    if (FB_W == 160) begin : g_shift_add
      // 160 = 128 + 32
      assign addr = (yw << 7) + (yw << 5) + xw;
    end else begin : g_mult
      assign addr = (yw * ADDR_W'(FB_W)) + xw;
    end
  endgenerate

endmodule

// File: rtl/fb_arbiter.sv
// Frame-buffer RAM arbiter: display fetch > clear engine (FB_CLEAR_EN) > draw client.
// Pixel and syncs leave two cycles after the coordinate that produced them.
//
// Clear FSM (present only with FB_CLEAR_EN)
//   state    | meaning
//   CLR_IDLE | no fill pending; draw client owns the free RAM cycles
//   CLR_RUN  | filling 0..FB_W*FB_H-1 on every cycle display leaves free
module fb_arbiter #(
  parameter int FB_W     = fb_pkg::FB_W,
  parameter int FB_H     = fb_pkg::FB_H,
  parameter int SCALE_SH = fb_pkg::SCALE_SH,
  parameter int PIX_W    = fb_pkg::PIX_W,
  parameter int ADDR_W   = fb_pkg::ADDR_W,
  parameter int H_ACTIVE = fb_pkg::H_ACTIVE,
  parameter int V_ACTIVE = fb_pkg::V_ACTIVE
) (
  input  logic              vgaclk,
  input  logic              reset,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              hsync,
  input  logic              vsync,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [7:0]        wr_x,
  input  logic [6:0]        wr_y,
  input  logic [PIX_W-1:0]  wr_color,
  input  logic              clear_start,
  input  logic [PIX_W-1:0]  clear_color,
  output logic              clear_busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [PIX_W-1:0]  ram_wdata,
  input  logic [PIX_W-1:0]  ram_rdata,
  output logic [PIX_W-1:0]  pixel,
  output logic              hsync_o,
  output logic              vsync_o
);

  import fb_pkg::*;

  localparam logic [9:0] H_LIM  = 10'(H_ACTIVE);
  localparam logic [9:0] V_LIM  = 10'(V_ACTIVE);
  localparam logic [9:0] FBW_LIM = 10'(FB_W);
  localparam logic [9:0] FBH_LIM = 10'(FB_H);

  logic              active;
  logic              disp_need;
  logic [9:0]        xs;
  logic [9:0]        ys;
  logic [ADDR_W-1:0] disp_addr;
  logic [9:0]        wx;
  logic [9:0]        wy;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_in_range;
  logic              wr_fire;
  logic              clr_wr;
  logic [ADDR_W-1:0] clr_addr;
  logic [PIX_W-1:0]  clr_data;
  grant_e            grant;

  assign active    = (x < H_LIM) && (y < V_LIM);
  assign disp_need = active && (x[SCALE_SH-1:0] == '0);

  assign xs = x >> SCALE_SH;
  assign ys = y >> SCALE_SH;

  fb_addr_gen #(.FB_W(FB_W), .ADDR_W(ADDR_W)) u_disp_addr (
    .xf   (xs),
    .yf   (ys),
    .addr (disp_addr)
  );

  assign wx = {2'b00, wr_x};
  assign wy = {3'b000, wr_y};

  fb_addr_gen #(.FB_W(FB_W), .ADDR_W(ADDR_W)) u_wr_addr (
    .xf   (wx),
    .yf   (wy),
    .addr (wr_addr)
  );

  // Out-of-range draws still complete the handshake; they just never reach the RAM.
  assign wr_in_range = (wx < FBW_LIM) && (wy < FBH_LIM);
  assign wr_ready    = !disp_need && !clear_busy;
  assign wr_fire     = wr_valid && wr_ready;

`ifdef FB_CLEAR_EN
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(FB_W * FB_H - 1);

  clr_state_e        clr_state;
  clr_state_e        clr_next;
  logic [ADDR_W-1:0] clr_cnt;
  logic [PIX_W-1:0]  clr_color_q;

  always_ff @(posedge vgaclk) begin
    if (reset) begin
      clr_state   <= CLR_IDLE;
      clr_cnt     <= '0;
      clr_color_q <= '0;
    end else begin
      clr_state <= clr_next;
      if ((clr_state == CLR_IDLE) && clear_start) begin
        clr_cnt     <= '0;
        clr_color_q <= clear_color;
      end else if (clr_wr) begin
        clr_cnt <= clr_cnt + ADDR_W'(1);
      end
    end
  end

  always_comb begin
    clr_next = clr_state;
    case (clr_state)
      CLR_IDLE: if (clear_start) clr_next = CLR_RUN;
      CLR_RUN:  if (!disp_need && (clr_cnt == CLR_LAST)) clr_next = CLR_IDLE;
      default:  clr_next = CLR_IDLE;
    endcase
  end

  always_comb begin
    clear_busy = (clr_state == CLR_RUN);
    clr_wr     = (clr_state == CLR_RUN) && !disp_need;
  end

  assign clr_addr = clr_cnt;
  assign clr_data = clr_color_q;
`else
  logic unused_clear;
  assign unused_clear = ^{clear_start, clear_color};
  assign clear_busy   = 1'b0;
  assign clr_wr       = 1'b0;
  assign clr_addr     = '0;
  assign clr_data     = '0;
`endif

  always_comb begin
    grant = GNT_NONE;
    if (disp_need) begin
      grant = GNT_DISP;
    end else if (clr_wr) begin
      grant = GNT_CLEAR;
    end else if (wr_fire) begin
      grant = GNT_WRITE;
    end
  end

  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    case (grant)
      GNT_DISP: begin
        ram_addr = disp_addr;
      end
      GNT_CLEAR: begin
        ram_addr  = clr_addr;
        ram_we    = 1'b1;
        ram_wdata = clr_data;
      end
      GNT_WRITE: begin
        ram_addr  = wr_addr;
        ram_we    = wr_in_range;
        ram_wdata = wr_color;
      end
      default: ;
    endcase
  end

  logic             rd_d1;
  logic             act_d1;
  logic             act_d2;
  logic             hs_d1;
  logic             vs_d1;
  logic [PIX_W-1:0] pix_q;

  // pix_q only reloads after a display read, so it holds across the replicated columns.
  always_ff @(posedge vgaclk) begin
    if (reset) begin
      rd_d1   <= 1'b0;
      act_d1  <= 1'b0;
      act_d2  <= 1'b0;
      hs_d1   <= 1'b1;
      vs_d1   <= 1'b1;
      hsync_o <= 1'b1;
      vsync_o <= 1'b1;
      pix_q   <= '0;
    end else begin
      rd_d1   <= (grant == GNT_DISP);
      act_d1  <= active;
      act_d2  <= act_d1;
      hs_d1   <= hsync;
      vs_d1   <= vsync;
      hsync_o <= hs_d1;
      vsync_o <= vs_d1;
      if (rd_d1) begin
        pix_q <= ram_rdata;
      end
    end
  end

  assign pixel = act_d2 ? pix_q : '0;

endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: vector table, randomized traffic against a behavioural
// frame-buffer model, and hand-written fetch / clear / reset sequences.
module tb_fb_arbiter;
  import fb_pkg::*;

  localparam int RAM_N = 1 << ADDR_W;

  logic              vgaclk = 1'b0;
  logic              reset;
  logic [9:0]        x;
  logic [9:0]        y;
  logic              hsync;
  logic              vsync;
  logic              wr_valid;
  logic              wr_ready;
  logic [7:0]        wr_x;
  logic [6:0]        wr_y;
  logic [PIX_W-1:0]  wr_color;
  logic              clear_start;
  logic [PIX_W-1:0]  clear_color;
  logic              clear_busy;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [PIX_W-1:0]  ram_wdata;
  logic [PIX_W-1:0]  ram_rdata;
  logic [PIX_W-1:0]  pixel;
  logic              hsync_o;
  logic              vsync_o;

  fb_arbiter dut (
    .vgaclk      (vgaclk),
    .reset       (reset),
    .x           (x),
    .y           (y),
    .hsync       (hsync),
    .vsync       (vsync),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
    .wr_color    (wr_color),
    .clear_start (clear_start),
    .clear_color (clear_color),
    .clear_busy  (clear_busy),
    .ram_addr    (ram_addr),
    .ram_we      (ram_we),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .pixel       (pixel),
    .hsync_o     (hsync_o),
    .vsync_o     (vsync_o)
  );

  always #5 vgaclk = ~vgaclk;

  function automatic logic [PIX_W-1:0] init_val(input int i);
    return PIX_W'((i * 7) ^ (i >> 5));
  endfunction

  // Single-port RAM with one cycle of read latency.
  logic [PIX_W-1:0] ram [RAM_N];
  bit ram_init = 1'b0;
  always @(posedge vgaclk) begin
    if (!ram_init) begin
      for (int i = 0; i < RAM_N; i++) ram[i] <= init_val(i);
      ram_init <= 1'b1;
    end else begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      ram_rdata <= ram[ram_addr];
    end
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge vgaclk);
    #1;
  endtask

  typedef struct {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        wv;
    logic [7:0]  wx;
    logic [6:0]  wy;
    logic [3:0]  wc;
    logic        ready;
    logic        we;
    logic        chk_addr;
    logic [14:0] addr;
    logic [3:0]  wdata;
  } vec_t;

  vec_t tbl [9];
  logic [PIX_W-1:0] mem_ref [RAM_N];

  initial begin
    int xi, yi, wxi, wyi, wa, da, held, p0, p1;
    bit act, need, inr, h0, h1, v0, v1;
    logic hs_hist [8];
    int n, ord_err, rdy_err;

    tbl[0] = '{10'd0,   10'd0,   1'b1, 8'd10,  7'd3,   4'h5, 1'b0, 1'b0, 1'b1, 15'd0,     4'h0};
    tbl[1] = '{10'd1,   10'd0,   1'b1, 8'd10,  7'd3,   4'h5, 1'b1, 1'b1, 1'b1, 15'd490,   4'h5};
    tbl[2] = '{10'd700, 10'd0,   1'b1, 8'd160, 7'd3,   4'h5, 1'b1, 1'b0, 1'b0, 15'd0,     4'h0};
    tbl[3] = '{10'd8,   10'd4,   1'b0, 8'd0,   7'd0,   4'h0, 1'b0, 1'b0, 1'b1, 15'd162,   4'h0};
    tbl[4] = '{10'd639, 10'd479, 1'b1, 8'd159, 7'd119, 4'h7, 1'b1, 1'b1, 1'b1, 15'd19199, 4'h7};
    tbl[5] = '{10'd640, 10'd0,   1'b1, 8'd0,   7'd0,   4'h9, 1'b1, 1'b1, 1'b1, 15'd0,     4'h9};
    tbl[6] = '{10'd636, 10'd479, 1'b1, 8'd3,   7'd3,   4'h1, 1'b0, 1'b0, 1'b1, 15'd19199, 4'h0};
    tbl[7] = '{10'd100, 10'd480, 1'b1, 8'd5,   7'd120, 4'h2, 1'b1, 1'b0, 1'b0, 15'd0,     4'h0};
    tbl[8] = '{10'd2,   10'd10,  1'b0, 8'd0,   7'd0,   4'h0, 1'b1, 1'b0, 1'b0, 15'd0,     4'h0};

    for (int i = 0; i < RAM_N; i++) mem_ref[i] = init_val(i);

    reset = 1'b1; x = 10'd700; y = 10'd500; hsync = 1'b0; vsync = 1'b0;
    wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_color = '0;
    clear_start = 1'b0; clear_color = '0;
    tick();
    tick();
    chk("reset_pixel", pixel, 0);
    chk("reset_hsync_o", hsync_o, 1);
    chk("reset_vsync_o", vsync_o, 1);
    chk("reset_clear_busy", clear_busy, 0);
    chk("reset_wr_ready", wr_ready, 1);
    reset = 1'b0;

    // Randomized traffic against a frame-buffer model built from the arbitration rules.
    held = 0; p0 = 0; p1 = 0; h0 = 1; h1 = 1; v0 = 1; v1 = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) begin
        x = 10'($urandom_range(799));
        y = 10'($urandom_range(524));
      end else begin
        x = (x >= 10'd799) ? 10'd0 : x + 10'd1;
        if (x == 10'd0) y = (y >= 10'd524) ? 10'd0 : y + 10'd1;
      end
      hsync    = 1'($urandom_range(1));
      vsync    = 1'($urandom_range(1));
      wr_valid = 1'($urandom_range(1));
      wr_x     = 8'($urandom_range(175));
      wr_y     = 7'($urandom_range(127));
      wr_color = 4'($urandom_range(15));
      xi = int'(x); yi = int'(y); wxi = int'(wr_x); wyi = int'(wr_y);
      act  = (xi < 640) && (yi < 480);
      need = act && (xi % 4 == 0);
      #1;
      chk("rnd_wr_ready", wr_ready, !need);
      if (need) begin
        da = (yi / 4) * 160 + xi / 4;
        chk("rnd_disp_addr", ram_addr, da);
        chk("rnd_disp_we", ram_we, 0);
        held = int'(mem_ref[da]);
      end else if (wr_valid) begin
        inr = (wxi < 160) && (wyi < 120);
        wa  = wyi * 160 + wxi;
        chk("rnd_wr_we", ram_we, inr);
        chk("rnd_wr_addr", ram_addr, wa);
        if (inr) begin
          chk("rnd_wr_data", ram_wdata, wr_color);
          mem_ref[wa] = wr_color;
        end
      end else begin
        chk("rnd_idle_we", ram_we, 0);
      end
      if (i >= 2) begin
        chk("rnd_pixel", pixel, p1);
        chk("rnd_hsync_o", hsync_o, h1);
        chk("rnd_vsync_o", vsync_o, v1);
      end
      p1 = p0; p0 = act ? held : 0;
      h1 = h0; h0 = hsync;
      v1 = v0; v0 = vsync;
      tick();
    end

    for (int k = 0; k < 9; k++) begin
      x = tbl[k].x; y = tbl[k].y;
      wr_valid = tbl[k].wv; wr_x = tbl[k].wx; wr_y = tbl[k].wy; wr_color = tbl[k].wc;
      #1;
      chk($sformatf("tbl%0d_wr_ready", k), wr_ready, tbl[k].ready);
      chk($sformatf("tbl%0d_ram_we", k), ram_we, tbl[k].we);
      if (tbl[k].chk_addr) chk($sformatf("tbl%0d_ram_addr", k), ram_addr, tbl[k].addr);
      if (tbl[k].we) chk($sformatf("tbl%0d_ram_wdata", k), ram_wdata, tbl[k].wdata);
      tick();
    end

    // Display fetch of (8,4): plant 4'hA at 162 through the writer, then scan.
    x = 10'd700; y = 10'd0; wr_valid = 1'b1; wr_x = 8'd2; wr_y = 7'd1; wr_color = 4'hA;
    #1;
    chk("fetch_plant_we", ram_we, 1);
    chk("fetch_plant_addr", ram_addr, 162);
    tick();
    wr_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      x = 10'(8 + i); y = 10'd4; hsync = (i % 3 == 0); vsync = 1'b1;
      hs_hist[i] = hsync;
      #1;
      if (i == 0) begin
        chk("fetch_addr", ram_addr, 162);
        chk("fetch_we", ram_we, 0);
      end
      if (i >= 2) chk($sformatf("fetch_hsync_o_%0d", i), hsync_o, hs_hist[i-2]);
      if (i >= 2 && i <= 5) chk($sformatf("fetch_pixel_%0d", i), pixel, 4'hA);
      tick();
    end

    x = 10'd700; y = 10'd0;
`ifdef FB_CLEAR_EN
    // Clear during blanking, racing a writer transfer on the start cycle.
    wr_valid = 1'b1; wr_x = 8'd5; wr_y = 7'd0; wr_color = 4'h6;
    clear_start = 1'b1; clear_color = 4'h3;
    #1;
    chk("clr_race_we", ram_we, 1);
    chk("clr_race_addr", ram_addr, 5);
    chk("clr_race_wdata", ram_wdata, 6);
    tick();
    n = 0; ord_err = 0; rdy_err = 0;
    while (n < 20000) begin
      clear_start = (n == 100);
      clear_color = (n == 100) ? 4'h9 : 4'h0;
      #1;
      if (!clear_busy) break;
      if (ram_we !== 1'b1 || ram_addr !== 15'(n) || ram_wdata !== 4'h3) ord_err++;
      if (wr_ready !== 1'b0) rdy_err++;
      tick();
      n++;
    end
    clear_start = 1'b0;
    chk("clr_busy_cycles", n, 19200);
    chk("clr_order_errors", ord_err, 0);
    chk("clr_ready_errors", rdy_err, 0);
    chk("clr_after_ready", wr_ready, 1);
    chk("clr_after_we", ram_we, 1);
    chk("clr_after_addr", ram_addr, 5);
    tick();
    wr_valid = 1'b0;

    clear_start = 1'b1; clear_color = 4'h4;
    tick();
    clear_start = 1'b0;
    repeat (500) tick();
    chk("mid_busy_before_reset", clear_busy, 1);
    reset = 1'b1;
    tick();
    chk("mid_reset_busy", clear_busy, 0);
    reset = 1'b0;
    clear_start = 1'b1; clear_color = 4'h4;
    tick();
    clear_start = 1'b0;
    chk("restart_busy", clear_busy, 1);
    chk("restart_addr0", ram_addr, 0);
    chk("restart_we", ram_we, 1);
    chk("restart_wdata", ram_wdata, 4);
    tick();
    chk("restart_addr1", ram_addr, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
`else
    wr_valid = 1'b0;
    clear_start = 1'b1; clear_color = 4'h3;
    #1;
    chk("noclr_start_busy", clear_busy, 0);
    chk("noclr_start_we", ram_we, 0);
    tick();
    clear_start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("noclr_busy_%0d", k), clear_busy, 0);
      chk($sformatf("noclr_we_%0d", k), ram_we, 0);
      tick();
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
